// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: fixed-latency load/store access
// that stalls the pipeline while busy and pulses resp_valid on completion.
// Ports: clk, reset (sync, active-high); req_valid/req_we/req_addr/req_be/
// req_wdata from MEM; stall to hazard unit; resp_valid/resp_rdata back.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  mem_wr;

  logic [31:0] mem [DEPTH];

  // Byte offset and upper address bits do not select a word.
  logic addr_unused;
  assign addr_unused = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_wr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          idx_d   = req_addr[DEPTH_LOG2+1:2];
          be_d    = req_be;
          wdata_d = req_wdata;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Dropping req_valid mid-access is a pipeline flush.
        if (!req_valid) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (we_q) mem_wr = 1'b1;
          else      rdata_d = mem[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is not reset; reset only suppresses a pending write.
  always_ff @(posedge clk) begin
    if (mem_wr && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign stall      = req_valid && (state_q != DONE);
  assign resp_valid = (state_q == DONE);
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 15) checked
// against a cycle-age memory model plus hand-computed expectations.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        rv   [3];
  logic        rwe  [3];
  logic [31:0] radr [3];
  logic [3:0]  rbe  [3];
  logic [31:0] rwd  [3];
  logic        stl  [3];
  logic        rsp  [3];
  logic [31:0] rdt  [3];

  int LATS [3] = '{2, 1, 15};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit armed = 0;

  int          age   [3];
  logic        lwe   [3];
  int          lidx  [3];
  logic [3:0]  lbe   [3];
  logic [31:0] lwd   [3];
  logic [31:0] rexp  [3];
  logic [31:0] mm    [3][64];
  int          rcnt  [3];

  dmem_responder #(.DEPTH_LOG2(6), .LATENCY(2)) u0 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_we(rwe[0]),
    .req_addr(radr[0]), .req_be(rbe[0]), .req_wdata(rwd[0]),
    .stall(stl[0]), .resp_valid(rsp[0]), .resp_rdata(rdt[0]));

  dmem_responder #(.DEPTH_LOG2(6), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_we(rwe[1]),
    .req_addr(radr[1]), .req_be(rbe[1]), .req_wdata(rwd[1]),
    .stall(stl[1]), .resp_valid(rsp[1]), .resp_rdata(rdt[1]));

  dmem_responder #(.DEPTH_LOG2(6), .LATENCY(15)) u2 (
    .clk(clk), .reset(reset), .req_valid(rv[2]), .req_we(rwe[2]),
    .req_addr(radr[2]), .req_be(rbe[2]), .req_wdata(rwd[2]),
    .stall(stl[2]), .resp_valid(rsp[2]), .resp_rdata(rdt[2]));

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: age = cycles since accept; access lands after LAT busy cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) armed <= 1;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        age[i]  <= -1;
        rexp[i] <= 32'd0;
      end else if (age[i] == -1) begin
        if (rv[i]) begin
          lwe[i]  <= rwe[i];
          lidx[i] <= int'(radr[i][7:2]);
          lbe[i]  <= rbe[i];
          lwd[i]  <= rwd[i];
          age[i]  <= 1;
        end
      end else if (age[i] == LATS[i] + 1) begin
        age[i] <= -1;
      end else if (!rv[i]) begin
        age[i] <= -1;
      end else if (age[i] == LATS[i]) begin
        if (lwe[i]) begin
          for (int b = 0; b < 4; b++)
            if (lbe[i][b]) mm[i][lidx[i]][8*b +: 8] <= lwd[i][8*b +: 8];
        end else begin
          rexp[i] <= mm[i][lidx[i]];
        end
        age[i] <= LATS[i] + 1;
      end else begin
        age[i] <= age[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d stall c%0d", i, cyc), 32'(stl[i]),
            32'(rv[i] && (age[i] != LATS[i] + 1)));
        chk($sformatf("u%0d resp_valid c%0d", i, cyc), 32'(rsp[i]),
            32'(age[i] == LATS[i] + 1));
        chk($sformatf("u%0d resp_rdata c%0d", i, cyc), rdt[i], rexp[i]);
        if (rsp[i]) rcnt[i]++;
      end
    end
  end

  // Presents one request, counts stall cycles until the completion pulse.
  task automatic access(input int i, input logic we, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input bit hold, output int nst,
                        output logic [31:0] rd, output int start);
    bit done;
    done  = 0;
    nst   = 0;
    rd    = 'x;
    start = cyc;
    rv[i] = 1; rwe[i] = we; radr[i] = a; rbe[i] = be; rwd[i] = wd;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stl[i]) nst++;
      if (rsp[i]) begin
        rd   = rdt[i];
        done = 1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL u%0d timeout: got no resp_valid required 1", i);
    end
    @(posedge clk); #1;
    if (!hold) rv[i] = 0;
  endtask

  int          ns, c0, c1;
  logic [31:0] rd;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rv[i] = 0; rwe[i] = 0; radr[i] = 0; rbe[i] = 0; rwd[i] = 0;
      age[i] = -1; rexp[i] = 0; rcnt[i] = 0;
    end
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset stall", 32'(stl[0]), 0);
    chk("reset resp_valid", 32'(rsp[0]), 0);
    chk("reset rdata", rdt[0], 32'h0);
    @(posedge clk); #1;

    access(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, ns, rd, c0);
    chk("store stall cycles", ns, 3);
    access(0, 0, 32'h10, 4'hF, 32'h0, 0, ns, rd, c0);
    chk("load stall cycles", ns, 3);
    chk("load 0x10", rd, 32'hDEADBEEF);

    access(0, 1, 32'h20, 4'hF, 32'h11223344, 0, ns, rd, c0);
    access(0, 1, 32'h20, 4'h5, 32'hAABBCCDD, 0, ns, rd, c0);
    access(0, 0, 32'h20, 4'hF, 32'h0, 0, ns, rd, c0);
    chk("byte-enable merge", rd, 32'h11BB33DD);

    access(0, 1, 32'h30, 4'hF, 32'h0, 0, ns, rd, c0);
    rv[0] = 1; rwe[0] = 1; radr[0] = 32'h30; rbe[0] = 4'hF;
    rwd[0] = 32'h55;
    @(posedge clk); #1;
    rv[0] = 0;
    @(negedge clk);
    chk("flush stall", 32'(stl[0]), 0);
    chk("flush resp_valid", 32'(rsp[0]), 0);
    repeat (3) begin
      @(negedge clk);
      chk("flush no resp", 32'(rsp[0]), 0);
    end
    @(posedge clk); #1;
    access(0, 0, 32'h30, 4'hF, 32'h0, 0, ns, rd, c0);
    chk("load after flush", rd, 32'h0);

    access(0, 1, 32'h40, 4'hF, 32'h12345678, 0, ns, rd, c0);
    rv[0] = 1; rwe[0] = 1; radr[0] = 32'h40; rbe[0] = 4'hF;
    rwd[0] = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    rv[0] = 0;
    @(negedge clk);
    chk("post-reset stall", 32'(stl[0]), 0);
    chk("post-reset resp_valid", 32'(rsp[0]), 0);
    chk("post-reset rdata", rdt[0], 32'h0);
    @(posedge clk); #1;
    access(0, 0, 32'h40, 4'hF, 32'h0, 0, ns, rd, c0);
    chk("load after reset", rd, 32'h12345678);

    access(0, 1, 32'h004, 4'hF, 32'h00000001, 1, ns, rd, c0);
    access(0, 0, 32'h104, 4'hF, 32'h0, 0, ns, rd, c1);
    chk("back-to-back spacing", c1 - c0, 4);
    chk("back-to-back stall", ns, 3);
    chk("wrap load 0x104", rd, 32'h00000001);

    access(0, 1, 32'h10, 4'h0, 32'hFFFFFFFF, 0, ns, rd, c0);
    access(0, 0, 32'h10, 4'hF, 32'h0, 0, ns, rd, c0);
    chk("be=0 store no change", rd, 32'hDEADBEEF);

    access(1, 1, 32'h8, 4'hF, 32'hA5A5A5A5, 0, ns, rd, c0);
    chk("lat1 store stall", ns, 2);
    access(1, 0, 32'h8, 4'hF, 32'h0, 0, ns, rd, c0);
    chk("lat1 load stall", ns, 2);
    chk("lat1 load data", rd, 32'hA5A5A5A5);

    access(2, 1, 32'hFC, 4'hF, 32'h5A5A0FF0, 0, ns, rd, c0);
    chk("lat15 store stall", ns, 16);
    access(2, 0, 32'hFC, 4'hF, 32'h0, 0, ns, rd, c0);
    chk("lat15 load stall", ns, 16);
    chk("lat15 load data", rd, 32'h5A5A0FF0);

    repeat (2) @(posedge clk);
    chk("lat1 resp pulses", rcnt[1], 2);
    chk("lat15 resp pulses", rcnt[2], 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
